// File: rtl/onehot_dec_to_bin_pkg.sv
// Shared widths and state encoding for the one-hot decimal to binary converter.
package onehot_dec_to_bin_pkg;

    // One dekatron digit is ten cathode lines; its BCD form is four bits.
    localparam int unsigned DIGIT_W = 10;
    localparam int unsigned BCD_W   = 4;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/onehot_dec_to_bin_decode.sv
// Combinational decode of one ten-line one-hot digit into 8-4-2-1 BCD.
module dek_digit_decode
    import onehot_dec_to_bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               onehot_ok_o
);

    logic [BCD_W-1:0] bcd_raw;

    // OR-tree encode; only trusted when exactly one line is set, else forced to 0.
    always_comb begin
        bcd_raw[0]  = digit_i[1] | digit_i[3] | digit_i[5] | digit_i[7] | digit_i[9];
        bcd_raw[1]  = digit_i[2] | digit_i[3] | digit_i[6] | digit_i[7];
        bcd_raw[2]  = digit_i[4] | digit_i[5] | digit_i[6] | digit_i[7];
        bcd_raw[3]  = digit_i[8] | digit_i[9];
        onehot_ok_o = (digit_i != '0) &&
                      ((digit_i & (digit_i - DIGIT_W'(1))) == '0);
        bcd_o       = onehot_ok_o ? bcd_raw : '0;
    end

endmodule

// File: rtl/onehot_dec_to_bin.sv
// Serial one-hot decimal word to BCD/binary converter, one digit per cycle MSD first.
module onehot_dec_to_bin
    import onehot_dec_to_bin_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [DIGITS*DIGIT_W-1:0] in_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [DIGITS*BCD_W-1:0]   bcd_o,
    output logic [BIN_W-1:0]          bin_o,
    output logic                      err_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    localparam int unsigned IN_W  = DIGITS * DIGIT_W;
    localparam int unsigned OBW   = DIGITS * BCD_W;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]         state_q, state_d;
    logic [IN_W-1:0]    in_q, in_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [OBW-1:0]     bcd_q, bcd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [IDX_W-1:0]   pos;
    logic [DIGIT_W-1:0] digit_sel;
    logic [BCD_W-1:0]   dec_bcd;
    logic               dec_ok;
    logic [BIN_W-1:0]   acc_x10;

    // Index counts conversion steps; position walks from the most significant digit down.
    assign pos = IDX_W'(DIGITS - 1) - idx_q;

    // Select the digit currently being converted from the captured word.
    always_comb begin
        digit_sel = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (pos == IDX_W'(k)) begin
                digit_sel = in_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    dek_digit_decode u_decode (
        .digit_i     (digit_sel),
        .bcd_o       (dec_bcd),
        .onehot_ok_o (dec_ok)
    );

    assign acc_x10 = (acc_q << 3) + (acc_q << 1);

    // Next-state and next-output logic for the IDLE/CONV/DONE controller.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        err_d   = err_q;
        bcd_d   = bcd_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    in_d    = in_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    bcd_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d = acc_x10 + BIN_W'(dec_bcd);
                err_d = err_q | ~dec_ok;
                for (int k = 0; k < DIGITS; k++) begin
                    if (pos == IDX_W'(k)) begin
                        bcd_d[k*BCD_W +: BCD_W] = dec_bcd;
                    end
                end
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            in_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            bcd_q       <= bcd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign bcd_o       = bcd_q;
    assign bin_o       = acc_q;
    assign err_o       = err_q;

endmodule

// File: doc/onehot_dec_to_bin.md
ONEHOT_DEC_TO_BIN -- requirements
Module: onehot_dec_to_bin

Interface
REQ-001 Parameter DIGITS, default 3: number of decimal digits; range 1..6.
REQ-002 Parameter BIN_W, default 10: binary output width; SHALL be >= ceil(log2(10^DIGITS)).
REQ-003 Clk  input  1: single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1: reset; synchronous, active-low.
REQ-005 In  input  DIGITS*10: one-hot decimal digits (dekatron cathode positions), 10 bits per digit; digit k at bits [10k+9:10k]; digit DIGITS-1 most significant.
REQ-006 In_valid  input  1: In holds a word to convert.
REQ-007 In_ready  output  1: block can accept a word.
REQ-008 Bcd  output  DIGITS*4: 8-4-2-1 BCD of the accepted word, digit k at [4k+3:4k].
REQ-009 Bin  output  BIN_W: binary value of the accepted word.
REQ-010 Err  output  1: at least one accepted digit was not exactly one-hot.
REQ-011 Out_valid  output  1: Bcd/Bin/Err valid.
REQ-012 Out_ready  input  1: consumer accepts the result.

Function
REQ-013 States IDLE, CONV, DONE; one-hot or binary encoding permitted.
REQ-014 IDLE: In_ready=1, Out_valid=0; In_valid=1 latches In into an input register, clears accumulator, digit index, Err; next state CONV.
REQ-015 CONV: In_ready=0; one digit per cycle, MSD first: acc <= acc*10 + digit_value; digit's BCD written to Bcd slot.
REQ-016 After DIGITS CONV cycles, next state DONE.
REQ-017 Latency: handshake in cycle T -> Out_valid=1 from cycle T+DIGITS+1.
REQ-018 Per-digit decode: bit i alone set -> value i; Bcd[0]=b1|b3|b5|b7|b9, Bcd[1]=b2|b3|b6|b7, Bcd[2]=b4|b5|b6|b7, Bcd[3]=b8|b9.
REQ-019 Digit with zero or more than one bit set: value 0, Bcd slot 0, Err set sticky until next accept.
REQ-020 Accumulator arithmetic at BIN_W bits; overflow impossible under REQ-002; acc*10 = (acc<<3)+(acc<<1).
REQ-021 DONE: Out_valid=1; Bcd, Bin, Err stable while Out_ready=0.
REQ-022 DONE with Out_ready=1: next state IDLE, Out_valid=0 next cycle; no same-cycle re-accept (In_ready=0 in DONE).
REQ-023 In changes after accept have no effect on the conversion in progress.
REQ-024 In_valid in CONV/DONE ignored; word held by upstream until In_ready.

Reset
REQ-025 Rst_n=0 at a rising edge: state IDLE, In_ready=1, Out_valid=0, Bcd=0, Bin=0, Err=0, accumulator/index/input register 0.
REQ-026 Reset in CONV or DONE aborts the conversion; no Out_valid for it.
REQ-027 Reset overrides simultaneous In_valid or Out_ready.

Structure
REQ-028 Shared package: DIGIT_W=10, BCD_W=4, state encoding constants.
REQ-029 Sub-module dek_digit_decode: combinational 10-bit one-hot -> 4-bit BCD plus onehot_ok flag; one instance, muxed by digit index.
REQ-030 Bcd, Bin, Err registered outputs; no combinational path In -> outputs.

Verification
REQ-031 DIGITS=3, In digits 1,2,3 (MSD..LSD), In_valid pulse -> Out_valid at T+4, Bcd=0x123, Bin=123, Err=0.
REQ-032 Digits 9,9,9 -> Bin=999 (0x3E7), Bcd=0x999, Err=0; digits 0,0,0 -> Bin=0, Err=0.
REQ-033 Middle digit bits 2 and 5 set, others 4 and 7 -> Err=1, Bcd=0x407, Bin=407; middle digit all-zero -> same result.
REQ-034 Out_ready=0 for 5 cycles in DONE -> outputs stable, In_ready=0; Out_ready=1 -> IDLE next cycle, new word accepted cycle after.
REQ-035 Rst_n=0 during second CONV cycle -> next cycle IDLE, all outputs 0, no Out_valid; following word converts correctly.
REQ-036 DIGITS=6, BIN_W=20, digits 9,8,7,6,5,4 -> Out_valid at T+7, Bin=987654.
